// File: rtl/adder_tree_pkg.sv
// ----------------------------------------------------------------------------
// adder_tree_pkg
// Shared types and constants for the adder tree operand loader and its
// latency tracker.
//   ADDER_WIDTH_DEF : default operand width of the tree
//   NUM_SLOTS       : number of isum inputs on the widest (3-level) tree
//   slot_idx_t      : index of one operand slot
//   count_t         : operand count of a group (0..8)
//   state_e         : loader state
//   launch_tag_t    : {valid, count} record carried down the latency line
// ----------------------------------------------------------------------------
package adder_tree_pkg;

  localparam int unsigned ADDER_WIDTH_DEF = 23;
  localparam int unsigned NUM_SLOTS       = 8;

  typedef logic [2:0] slot_idx_t;
  typedef logic [3:0] count_t;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    LAUNCH = 1'b1
  } state_e;

  typedef struct packed {
    logic   valid;
    count_t count;
  } launch_tag_t;

  // A group closes on its GROUP_SIZE-th operand or on an explicit last marker.
  function automatic logic is_group_end(input count_t accepted,
                                        input count_t group_size,
                                        input logic   last);
    return (accepted == group_size) || last;
  endfunction

endpackage

// File: rtl/adder_tree_valid_pipe.sv
// ----------------------------------------------------------------------------
// adder_tree_valid_pipe
// Delay line that follows a launched group through the tree pipeline so the
// caller knows in which cycle the tree sum is valid and how many operands it
// covers.
//   clk_i   : clock, rising edge
//   clr_ni  : synchronous active-low clear, drops every tag in flight
//   valid_i : launch pulse entering the tree
//   count_i : operand count of that launch
//   valid_o : launch pulse delayed by DEPTH edges
//   count_o : count delayed by DEPTH edges
// ----------------------------------------------------------------------------
module adder_tree_valid_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   clr_ni,
  input  logic   valid_i,
  input  count_t count_i,
  output logic   valid_o,
  output count_t count_o
);

  launch_tag_t stage_q [DEPTH];

  // Shift the launch tags one stage per edge; several may be in flight.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= {valid_i, count_i};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[DEPTH-1].valid;
  assign count_o = stage_q[DEPTH-1].count;

endmodule

// File: rtl/adder_tree_operand_loader.sv
// ----------------------------------------------------------------------------
// adder_tree_operand_loader
// Packs a serial operand stream into the 8-slot operand bank of the adder
// tree, issues a one-cycle launch per group and flags when the tree sum of
// that group is valid.
//   clk_i       : clock, rising edge
//   rst_ni      : synchronous active-low reset
//   in_valid_i  : an operand is offered
//   in_ready_o  : loader accepts an operand this cycle
//   in_data_i   : operand value
//   in_last_i   : closes the group early (sampled on acceptance only)
//   op_bus_o    : slot k at bits [k*W +: W]; slot 0 -> isum0_0_0_0
//   op_launch_o : bank is complete and sampled by the tree this cycle
//   op_count_o  : operands in the launched group (valid with op_launch_o)
//   sum_valid_o : tree sum carries a launched group's result this cycle
//   sum_count_o : op_count_o aligned with sum_valid_o
// ----------------------------------------------------------------------------
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int unsigned ADDER_WIDTH  = ADDER_WIDTH_DEF,
  parameter int unsigned GROUP_SIZE   = 4,
  parameter int unsigned TREE_LATENCY = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [ADDER_WIDTH-1:0]           in_data_i,
  input  logic                             in_last_i,
  output logic [NUM_SLOTS*ADDER_WIDTH-1:0] op_bus_o,
  output logic                             op_launch_o,
  output count_t                           op_count_o,
  output logic                             sum_valid_o,
  output count_t                           sum_count_o
);

  localparam count_t GROUP_CNT = count_t'(GROUP_SIZE);

  state_e                 state_q, state_d;
  count_t                 wr_idx_q, wr_idx_d;
  logic [ADDER_WIDTH-1:0] slot_q [NUM_SLOTS];
  logic [ADDER_WIDTH-1:0] slot_d [NUM_SLOTS];
  logic                   in_ready_q, in_ready_d;
  logic                   op_launch_q, op_launch_d;
  count_t                 op_count_q, op_count_d;

  logic                   accept_s;
  logic                   group_end_s;
  count_t                 wr_idx_inc_s;
  slot_idx_t              wr_slot_s;

  // in_ready_q is low in reset and in LAUNCH, so it alone qualifies a handshake.
  assign accept_s     = in_valid_i && in_ready_q;
  assign wr_idx_inc_s = wr_idx_q + 4'd1;
  assign wr_slot_s    = wr_idx_q[2:0];
  assign group_end_s  = is_group_end(wr_idx_inc_s, GROUP_CNT, in_last_i);

  // State register together with the slot bank and the registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      op_launch_q <= 1'b0;
      op_count_q  <= '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      in_ready_q  <= in_ready_d;
      op_launch_q <= op_launch_d;
      op_count_q  <= op_count_d;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Next-state logic: FILL until the group closes, then a single LAUNCH cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept_s && group_end_s) begin
          state_d = LAUNCH;
        end else begin
          state_d = FILL;
        end
      end
      LAUNCH:  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Slot bank and write pointer; the tree samples the bank at the edge that
  // ends LAUNCH, so clearing at that same edge is safe.
  always_comb begin
    wr_idx_d = wr_idx_q;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      slot_d[k] = slot_q[k];
    end
    case (state_q)
      FILL: begin
        if (accept_s) begin
          wr_idx_d          = wr_idx_inc_s;
          slot_d[wr_slot_s] = in_data_i;
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      LAUNCH: begin
        wr_idx_d = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          slot_d[k] = '0;
        end
      end
      default: begin
        wr_idx_d = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          slot_d[k] = '0;
        end
      end
    endcase
    // Slots beyond the group size feed unused tree inputs and stay zero.
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      slot_d[k] = (k >= GROUP_SIZE) ? '0 : slot_d[k];
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    in_ready_d  = (state_d == FILL);
    op_launch_d = (state_d == LAUNCH);
    op_count_d  = (state_d == LAUNCH) ? wr_idx_d : 4'd0;
  end

  for (genvar k = 0; k < int'(NUM_SLOTS); k++) begin : g_pack
    assign op_bus_o[k*ADDER_WIDTH +: ADDER_WIDTH] = slot_q[k];
  end

  assign in_ready_o  = in_ready_q;
  assign op_launch_o = op_launch_q;
  assign op_count_o  = op_count_q;

  // Reset also flushes launches still inside the tree.
  adder_tree_valid_pipe #(
    .DEPTH (TREE_LATENCY)
  ) u_valid_pipe (
    .clk_i   (clk_i),
    .clr_ni  (rst_ni),
    .valid_i (op_launch_q),
    .count_i (op_count_q),
    .valid_o (sum_valid_o),
    .count_o (sum_count_o)
  );

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_adder_tree_operand_loader
// Directed table of groups, back-to-back streaming, randomly gapped groups and
// a reset-after-launch sequence. A two-stage model of the adder tree turns the
// operand bank into a sum that is compared when sum_valid_o is high.
// ----------------------------------------------------------------------------
module tb_adder_tree_operand_loader;
  import adder_tree_pkg::*;

  localparam int W   = 23;
  localparam int GS  = 4;
  localparam int LAT = 2;
  localparam int SW  = W + 3;
  localparam int NV  = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready_o;
  logic [W-1:0]         in_data;
  logic                 in_last;
  logic [8*W-1:0]       op_bus_o;
  logic                 op_launch_o;
  count_t               op_count_o;
  logic                 sum_valid_o;
  count_t               sum_count_o;

  adder_tree_operand_loader #(
    .ADDER_WIDTH  (W),
    .GROUP_SIZE   (GS),
    .TREE_LATENCY (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .op_bus_o    (op_bus_o),
    .op_launch_o (op_launch_o),
    .op_count_o  (op_count_o),
    .sum_valid_o (sum_valid_o),
    .sum_count_o (sum_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] slot(input int k);
    return op_bus_o[k*W +: W];
  endfunction

  // Model of the 2-level tree: input register at the launch edge, then sum.
  logic [SW-1:0] bus_sum_s, tree_s1, tree_sum;
  always_comb begin
    bus_sum_s = '0;
    for (int k = 0; k < 8; k++) bus_sum_s = bus_sum_s + SW'(op_bus_o[k*W +: W]);
  end
  always @(posedge clk) begin
    tree_s1  <= bus_sum_s;
    tree_sum <= tree_s1;
  end

  typedef struct {
    logic [3:0]    count;
    logic [SW-1:0] sum;
    int            cyc;
  } exp_t;

  exp_t launch_q[$];
  exp_t sum_q[$];
  int   launch_log[$];
  int   sv_log[$];

  logic out_of_rst = 1'b0;
  always @(posedge clk) out_of_rst <= rst_n;

  // Monitor: handshake gap, launch contents and aligned tree result.
  exp_t m_e;
  logic pad_ok;
  always @(negedge clk) begin
    if (out_of_rst) check("ready_vs_launch", in_ready_o, !op_launch_o);
    if (op_launch_o) begin
      check("launch_expected", launch_q.size() > 0, 1'b1);
      if (launch_q.size() > 0) begin
        m_e = launch_q.pop_front();
        check("op_count", op_count_o, m_e.count);
        check("launch_sum", bus_sum_s, m_e.sum);
        pad_ok = 1'b1;
        for (int k = 0; k < 8; k++)
          if (k >= int'(m_e.count) && slot(k) != '0) pad_ok = 1'b0;
        check("zero_pad", pad_ok, 1'b1);
        m_e.cyc = cyc;
        sum_q.push_back(m_e);
        launch_log.push_back(cyc);
      end
    end
    if (sum_valid_o) begin
      check("sum_valid_expected", sum_q.size() > 0, 1'b1);
      if (sum_q.size() > 0) begin
        m_e = sum_q.pop_front();
        check("sum_count", sum_count_o, m_e.count);
        check("tree_sum", tree_sum, m_e.sum);
        check("sum_latency", cyc - m_e.cyc, LAT);
        sv_log.push_back(cyc);
      end
    end
  end

  // Offer one operand from a negedge and hold it until accepted.
  task automatic send_op(input int idx, input logic [W-1:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_time", guard < 20, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("slot_written", slot(idx), d);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((launch_q.size() != 0 || sum_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", launch_q.size() + sum_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready_o, 1'b0);
    check({tag, "_op_bus"}, op_bus_o, '0);
    check({tag, "_op_launch"}, op_launch_o, 1'b0);
    check({tag, "_op_count"}, op_count_o, 4'd0);
    check({tag, "_sum_valid"}, sum_valid_o, 1'b0);
    check({tag, "_sum_count"}, sum_count_o, 4'd0);
  endtask

  typedef struct {
    int            n;
    logic [W-1:0]  d [4];
    logic          last;
    logic [3:0]    exp_count;
    logic [SW-1:0] exp_sum;
    int            exp_launch_dly;
  } vec_t;

  vec_t vec [NV];

  task automatic set_vec(input int i, input int n, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3, input logic last,
                         input logic [3:0] cnt, input logic [SW-1:0] sum, input int dly);
    vec[i].n = n;
    vec[i].d[0] = d0; vec[i].d[1] = d1; vec[i].d[2] = d2; vec[i].d[3] = d3;
    vec[i].last = last;
    vec[i].exp_count = cnt;
    vec[i].exp_sum = sum;
    vec[i].exp_launch_dly = dly;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    int s0;
    int lc;
    int n;
    logic [W-1:0]  d;
    logic [SW-1:0] sum;
    logic          last;

    set_vec(0, 4, 23'd1, 23'd2, 23'd3, 23'd4, 1'b0, 4'd4, 26'd10, 4);
    set_vec(1, 4, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 1'b0, 4'd4, 26'h1FFFFFC, 4);
    set_vec(2, 2, 23'd5, 23'd9, 23'd0, 23'd0, 1'b1, 4'd2, 26'd14, 2);
    set_vec(3, 1, 23'h123, 23'd0, 23'd0, 23'd0, 1'b1, 4'd1, 26'h123, 1);
    set_vec(4, 4, 23'h400000, 23'd1, 23'h3FFFFF, 23'd0, 1'b1, 4'd4, 26'h800000, 4);
    set_vec(5, 3, 23'd10, 23'd20, 23'd30, 23'd0, 1'b1, 4'd3, 26'd60, 3);

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready_o, 1'b1);

    // Directed groups from the table.
    for (int i = 0; i < NV; i++) begin
      launch_q.push_back('{vec[i].exp_count, vec[i].exp_sum, 0});
      start = cyc;
      for (int j = 0; j < vec[i].n; j++)
        send_op(j, vec[i].d[j], vec[i].last && (j == vec[i].n - 1));
      wait_drain(30);
      lc = (launch_log.size() > 0) ? launch_log[launch_log.size()-1] : -1;
      check("launch_cycle", lc - start, vec[i].exp_launch_dly);
    end

    // Two groups streamed with in_valid held high across the launch bubble.
    s0 = sv_log.size();
    launch_q.push_back('{4'd4, 26'd50, 0});
    launch_q.push_back('{4'd4, 26'd1000, 0});
    send_op(0, 23'd11, 1'b0); send_op(1, 23'd12, 1'b0);
    send_op(2, 23'd13, 1'b0); send_op(3, 23'd14, 1'b0);
    send_op(0, 23'd100, 1'b0); send_op(1, 23'd200, 1'b0);
    send_op(2, 23'd300, 1'b0); send_op(3, 23'd400, 1'b0);
    wait_drain(30);
    check("b2b_pulses", sv_log.size() - s0, 2);
    lc = (sv_log.size() >= s0 + 2) ? (sv_log[s0+1] - sv_log[s0]) : -1;
    check("b2b_spacing", lc, GS + 1);

    // Randomly gapped groups against the scoreboard.
    for (int g = 0; g < 100; g++) begin
      n    = $urandom_range(GS, 1);
      last = (n < GS) ? 1'b1 : 1'($urandom_range(1, 0));
      sum  = '0;
      for (int j = 0; j < n; j++) begin
        d = W'($urandom);
        sum = sum + SW'(d);
        if (j == 0) launch_q.push_back('{4'(n), 26'(0), 0});
        while ($urandom_range(1, 0) == 1) @(negedge clk);
        launch_q[launch_q.size()-1].sum = sum;
        send_op(j, d, last && (j == n - 1));
      end
    end
    wait_drain(100);

    // Reset in the cycle after a launch drops the pending result.
    s0 = sv_log.size();
    launch_q.push_back('{4'd4, 26'd10, 0});
    send_op(0, 23'd1, 1'b0); send_op(1, 23'd2, 1'b0);
    send_op(2, 23'd3, 1'b0); send_op(3, 23'd4, 1'b0);
    check("rst_seq_launch", op_launch_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sum_q.delete();
    @(negedge clk);
    check_reset_outputs("midflight");
    @(negedge clk);
    check_reset_outputs("midflight2");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", in_ready_o, 1'b1);
    repeat (3) @(negedge clk);
    check("suppressed_sum_valid", sv_log.size() - s0, 0);

    launch_q.push_back('{4'd4, 26'd20, 0});
    start = cyc;
    send_op(0, 23'd2, 1'b0); send_op(1, 23'd4, 1'b0);
    send_op(2, 23'd6, 1'b0); send_op(3, 23'd8, 1'b0);
    wait_drain(30);
    lc = (launch_log.size() > 0) ? launch_log[launch_log.size()-1] : -1;
    check("post_reset_launch_cycle", lc - start, 4);
    check("post_reset_pulses", sv_log.size() - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_operand_loader.md
# adder_tree_operand_loader

Upstream feeder for the adder tree. It accepts a serial stream of `ADDER_WIDTH`-bit operands over a valid/ready handshake and packs them into an 8-slot operand bank driven onto the tree's `isum*` inputs. When a group is complete it issues a one-cycle launch, and it tracks the tree's fixed pipeline latency to flag the cycle in which the tree's `sum` output is valid.

## Interface
Parameters:
- `ADDER_WIDTH`, 23, operand width; must match the tree.
- `GROUP_SIZE`, 4, operands per launch.
  - Legal values 1..8.
  - Use 4 for the 2-level tree (slots 0–3 summed) and 8 for the 3-level tree.
- `TREE_LATENCY`, 2, clock edges from the launch cycle to `sum` being valid at the tree output.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `in_valid` input 1 — an operand is offered.
- `in_ready` output 1 — loader can accept an operand this cycle.
- `in_data` input `ADDER_WIDTH` — operand value.
- `in_last` input 1 — qualifies `in_data`; closes the group early.
- `op_bus` output 8×`ADDER_WIDTH` — flattened slot bank, slot k at bits `[k*W +: W]`; slot 0 maps to `isum0_0_0_0`, slot 7 maps to `isum0_1_1_1`.
- `op_launch` output 1 — the bank is complete and is being sampled by the tree this cycle.
- `op_count` output 4 — number of valid operands in the launched group (1..`GROUP_SIZE`); meaningful while `op_launch` is high.
- `sum_valid` output 1 — the tree `sum` carries the result of a launched group this cycle.
- `sum_count` output 4 — `op_count` delayed to align with `sum_valid`.

## Operation
States:
- **FILL**
  - `in_ready`=1. An accepted operand (`in_valid`&`in_ready`) is written to slot `wr_idx`, and `wr_idx` increments.
  - The loader goes to LAUNCH when the accepted operand is the `GROUP_SIZE`-th of the group, or carries `in_last`=1.
- **LAUNCH**
  - Lasts exactly one cycle. `in_ready`=0, `op_launch`=1, `op_count`=`wr_idx`.
  - On exit: all slots are cleared to 0, `wr_idx` returns to 0, and the state returns to FILL.
- Slots at index ≥`GROUP_SIZE` are permanently 0.
- After an early `in_last`, unwritten slots stay 0 (zero padding), so the sum is unaffected.
- `in_last` with `GROUP_SIZE`-th operand: a single launch, `op_count`=`GROUP_SIZE`.
- `in_valid`=0 in FILL: no state change. Groups may stall indefinitely.
- An empty group is never launched: `in_last` without an accepted operand cannot occur, since `in_last` is only sampled on acceptance.
- Latency tracker: a `TREE_LATENCY`-deep shift register of {launch, count}. Its output drives `sum_valid`/`sum_count`.
- Width rule: the loader does no arithmetic. The tree result width is `ADDER_WIDTH`+log2(GROUP_SIZE) and cannot overflow.

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 in the first cycle after `rst_n` rises.
  - `op_bus`=0, `op_launch`=0, `op_count`=0, `sum_valid`=0, `sum_count`=0.
  - State FILL, `wr_idx`=0, delay line cleared.
- Minimum group period is `GROUP_SIZE`+1 cycles (one LAUNCH bubble).
- Operand accepted at edge e appears on `op_bus` in cycle e+1.
- Launch in cycle t produces `sum_valid`=1 in cycle t+`TREE_LATENCY`, for exactly one cycle.
- Back-to-back launches therefore give `sum_valid` pulses spaced ≥`GROUP_SIZE`+1 apart; the delay line must handle a launch entering while earlier ones are in flight.
- Slot clearing happens at the edge that ends LAUNCH. The tree's input register samples the pre-clear values at that same edge.
- Reset mid-group or mid-flight: partial slots are discarded, and no `sum_valid` is issued for pending launches.

## Structure
- Shared package `adder_tree_pkg`:
  - `ADDER_WIDTH` default and `NUM_SLOTS`=8.
  - Slot index type (3 bits) and count type (4 bits).
  - State enum `{FILL, LAUNCH}`.
- Sub-module `adder_tree_valid_pipe`: parameterised delay line carrying {valid, count}, depth `TREE_LATENCY`, synchronous active-low clear. The rest is inline.

## Test plan
- `GROUP_SIZE`=4, stream 1,2,3,4 on consecutive cycles:
  - `op_launch` in cycle 5, `op_count`=4, slots 0..3 = 1,2,3,4, slots 4..7 = 0.
  - `sum_valid` in cycle 7 with tree `sum`=10, `sum_count`=4.
- Values 0x7FFFFF ×4 → tree `sum`=0x1FFFFFC, `sum_valid` aligned, no truncation.
- `in_last` on the 2nd operand (5, 9) → `op_count`=2, slots 2..3 = 0, `sum`=14.
- Two groups driven continuously with `in_valid` held high:
  - `in_ready` is low exactly in each launch cycle.
  - Two `sum_valid` pulses 5 cycles apart, with the correct sums in order.
- Random `in_valid` gaps (50%) over 100 groups → scoreboard sums and counts match, with no lost or duplicated operands.
- `rst_n` asserted one cycle after a launch:
  - Pending `sum_valid` is suppressed; all outputs return to reset values.
  - The next group launches cleanly.
